// File: rtl/uart_pkg.sv
// Shared UART definitions: default word width, receive-entry layout and
// pointer-width helper used by the receive and transmit buffers.
package uart_pkg;

  localparam int unsigned UART_DATA_WIDTH = 8;

  // Layout of a stored receive entry when the parity tag is kept.
  typedef struct packed {
    logic                       parity_err;
    logic [UART_DATA_WIDTH-1:0] data;
  } uart_rx_entry_t;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic single-clock first-word-fall-through FIFO with occupancy count.
// Writes while full are accepted only when a read happens in the same cycle.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = UART_DATA_WIDTH,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned PW   = ptr_width(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_fire, rd_fire;

  always_comb begin
    rd_fire  = rd_en & (count_q != '0);
    wr_fire  = wr_en & ((count_q != CW'(DEPTH)) | rd_fire);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_fire) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; entries are only readable once count covers them.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: one push per rx_done rising edge, FWFT valid/ready output,
// sticky overrun/framing status. Define UART_RX_FIFO_PARITY_TAG_EN to store parity.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx_done,
  input  logic [DATA_WIDTH-1:0]   rx_data,
  input  logic                    rx_parity_error,
  input  logic                    rx_framing_error,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_WIDTH-1:0]   m_data,
  output logic                    m_parity_err,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty,
  output logic                    overrun,
  output logic                    framing_seen,
  input  logic                    clr_status
);

`ifdef UART_RX_FIFO_PARITY_TAG_EN
  localparam int unsigned ENTRY_W = DATA_WIDTH + 1;
`else
  localparam int unsigned ENTRY_W = DATA_WIDTH;
`endif

  logic               done_q, done_d;
  logic               fe_q, fe_d;
  logic               overrun_q, overrun_d;
  logic               framing_seen_q, framing_seen_d;
  logic               push, pop, fe_rise;
  logic [ENTRY_W-1:0] wr_entry, rd_entry;

  always_comb begin
    done_d         = rx_done;
    fe_d           = rx_framing_error;
    push           = rx_done & ~done_q;
    fe_rise        = rx_framing_error & ~fe_q;
    pop            = m_valid & m_ready;
    // A new event in the same cycle as clr_status must survive the clear.
    overrun_d      = (push & full & ~pop) | (overrun_q & ~clr_status);
    framing_seen_d = fe_rise | (framing_seen_q & ~clr_status);
  end

  // NOTE: edge history resets high so a level already present at release is ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q         <= 1'b1;
      fe_q           <= 1'b1;
      overrun_q      <= 1'b0;
      framing_seen_q <= 1'b0;
    end else begin
      done_q         <= done_d;
      fe_q           <= fe_d;
      overrun_q      <= overrun_d;
      framing_seen_q <= framing_seen_d;
    end
  end

`ifdef UART_RX_FIFO_PARITY_TAG_EN
  assign wr_entry     = {rx_parity_error, rx_data};
  assign m_data       = rd_entry[DATA_WIDTH-1:0];
  assign m_parity_err = rd_entry[DATA_WIDTH];
`else
  logic parity_unused;
  assign parity_unused = rx_parity_error;
  assign wr_entry      = rx_data;
  assign m_data        = rd_entry;
  assign m_parity_err  = 1'b0;
`endif

  uart_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (wr_entry),
    .rd_en   (pop),
    .rd_data (rd_entry),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  assign m_valid      = ~empty;
  assign overrun      = overrun_q;
  assign framing_seen = framing_seen_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model compared
// every cycle, plus directed literal expectations for each scenario.
module tb_uart_rx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
`ifdef UART_RX_FIFO_PARITY_TAG_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx_done = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic          rx_parity_error = 1'b0;
  logic          rx_framing_error = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_parity_err;
  logic [4:0]    count;
  logic          full, empty, overrun, framing_seen;
  logic          clr_status = 1'b0;

  int errors = 0;
  int checks = 0;

  uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .rx_done          (rx_done),
    .rx_data          (rx_data),
    .rx_parity_error  (rx_parity_error),
    .rx_framing_error (rx_framing_error),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .m_data           (m_data),
    .m_parity_err     (m_parity_err),
    .count            (count),
    .full             (full),
    .empty            (empty),
    .overrun          (overrun),
    .framing_seen     (framing_seen),
    .clr_status       (clr_status)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a queue of {parity, data} words plus sticky flags.
  logic [DW:0] mq[$];
  bit          m_done_prev, m_fe_prev, m_ovr, m_fs;

  // Inputs change only just after a falling edge, so the values seen here are
  // exactly those the DUT sampled at the preceding rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        mq.delete();
        m_done_prev = 1'b1;
        m_fe_prev   = 1'b1;
        m_ovr       = 1'b0;
        m_fs        = 1'b0;
      end else begin
        bit push, pop, fe_rise, was_full;
        push        = rx_done && !m_done_prev;
        fe_rise     = rx_framing_error && !m_fe_prev;
        m_done_prev = rx_done;
        m_fe_prev   = rx_framing_error;
        pop         = m_ready && (mq.size() != 0);
        was_full    = (mq.size() == DEPTH);
        if (clr_status) begin
          m_ovr = 1'b0;
          m_fs  = 1'b0;
        end
        if (pop) mq.delete(0);
        if (push) begin
          if (!was_full || pop) mq.push_back({rx_parity_error, rx_data});
          else                  m_ovr = 1'b1;
        end
        if (fe_rise) m_fs = 1'b1;
      end
      check("m_valid", 32'(m_valid), 32'(mq.size() != 0));
      check("count", 32'(count), 32'(mq.size()));
      check("full", 32'(full), 32'(mq.size() == DEPTH));
      check("empty", 32'(empty), 32'(mq.size() == 0));
      check("overrun", 32'(overrun), 32'(m_ovr));
      check("framing_seen", 32'(framing_seen), 32'(m_fs));
      if (mq.size() != 0) begin
        check("m_data", 32'(m_data), 32'(mq[0][DW-1:0]));
        check("m_parity_err", 32'(m_parity_err), 32'(PAR_EN & mq[0][DW]));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic frame(input logic [DW-1:0] d, input logic perr);
    rx_done = 1'b1;
    rx_data = d;
    rx_parity_error = perr;
    step(1);
    rx_done = 1'b0;
    rx_parity_error = 1'b0;
    step(1);
  endtask

  initial begin
    // Reset state
    step(3);
    check("reset_empty", 32'(empty), 32'd1);
    check("reset_count", 32'(count), 32'd0);
    check("reset_valid", 32'(m_valid), 32'd0);
    check("reset_full", 32'(full), 32'd0);
    rst = 1'b1;
    step(2);

    // Long rx_done pulse gives exactly one entry
    rx_done = 1'b1;
    rx_data = 8'hA5;
    step(1);
    check("t1_valid", 32'(m_valid), 32'd1);
    check("t1_data", 32'(m_data), 32'hA5);
    check("t1_count", 32'(count), 32'd1);
    step(15);
    check("t1_count_held", 32'(count), 32'd1);
    rx_done = 1'b0;
    m_ready = 1'b1;
    step(1);
    m_ready = 1'b0;
    check("t1_empty", 32'(empty), 32'd1);

    // Fill, overflow, drain in order
    for (int i = 0; i < DEPTH; i++) frame(8'(i), 1'b0);
    check("t2_full", 32'(full), 32'd1);
    check("t2_count", 32'(count), 32'd16);
    check("t2_no_ovr", 32'(overrun), 32'd0);
    frame(8'hFF, 1'b0);
    check("t2_overrun", 32'(overrun), 32'd1);
    check("t2_count_ovr", 32'(count), 32'd16);
    m_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check("t2_drain", 32'(m_data), 32'(i));
      step(1);
    end
    m_ready = 1'b0;
    check("t2_empty", 32'(empty), 32'd1);
    check("t2_ovr_sticky", 32'(overrun), 32'd1);
    clr_status = 1'b1;
    step(1);
    clr_status = 1'b0;
    check("t2_ovr_clr", 32'(overrun), 32'd0);

    // Push while full with a simultaneous pop
    for (int i = 0; i < DEPTH; i++) frame(8'(8'h10 + i), 1'b0);
    rx_done = 1'b1;
    rx_data = 8'h3C;
    m_ready = 1'b1;
    step(1);
    rx_done = 1'b0;
    m_ready = 1'b0;
    check("t3_count", 32'(count), 32'd16);
    check("t3_no_ovr", 32'(overrun), 32'd0);
    step(1);
    m_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check("t3_drain", 32'(m_data), (i < DEPTH - 1) ? 32'(8'h11 + i) : 32'h3C);
      step(1);
    end
    m_ready = 1'b0;
    check("t3_empty", 32'(empty), 32'd1);

    // Parity tag
    frame(8'h81, 1'b1);
    check("t4_data", 32'(m_data), 32'h81);
    check("t4_parity", 32'(m_parity_err), 32'(PAR_EN));
    m_ready = 1'b1;
    step(1);
    m_ready = 1'b0;

    // Framing edge coincident with clear: set wins
    rx_framing_error = 1'b1;
    clr_status = 1'b1;
    step(1);
    clr_status = 1'b0;
    check("t5_fs_set", 32'(framing_seen), 32'd1);
    step(2);
    check("t5_fs_hold", 32'(framing_seen), 32'd1);
    clr_status = 1'b1;
    step(1);
    clr_status = 1'b0;
    check("t5_fs_clr", 32'(framing_seen), 32'd0);
    rx_framing_error = 1'b0;
    step(2);

    // Reset with stored entries and rx_done held high
    for (int i = 0; i < 5; i++) frame(8'(8'h50 + i), 1'b0);
    check("t6_count5", 32'(count), 32'd5);
    rx_done = 1'b1;
    rx_data = 8'h55;
    step(1);
    rst = 1'b0;
    #1;
    check("t6_async_empty", 32'(empty), 32'd1);
    step(2);
    rst = 1'b1;
    step(3);
    check("t6_empty", 32'(empty), 32'd1);
    check("t6_count", 32'(count), 32'd0);
    rx_done = 1'b0;
    step(1);
    rx_done = 1'b1;
    rx_data = 8'h77;
    step(1);
    rx_done = 1'b0;
    check("t6_count1", 32'(count), 32'd1);
    check("t6_data", 32'(m_data), 32'h77);
    m_ready = 1'b1;
    step(2);
    m_ready = 1'b0;
    check("t6_final_empty", 32'(empty), 32'd1);
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
